// File: rtl/mode7_vga_scan.sv
// Raster scan generator and 3-3-2 VGA pixel sink for the Mode 7 renderer, with per-frame angle.
// Optional sky fill above a horizon row is enabled by defining MODE7_HORIZON_EN.
module mode7_vga_scan #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned PIPE_LAT  = 1,
   parameter int unsigned HORIZON   = 120,
   parameter logic [7:0]  SKY_COLOR = 8'h13
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_ce_i,
   input  logic [7:0]  color_i,
   input  logic [15:0] angle_step_i,
   output logic [15:0] x_o,
   output logic [15:0] y_o,
   output logic [15:0] angle_o,
   output logic [7:0]  rgb_o,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        frame_start_o
);

`ifdef MODE7_HORIZON_EN
   localparam logic HorizonEn = 1'b1;
`else
   localparam logic HorizonEn = 1'b0;
`endif

   localparam logic [15:0] HVis    = 16'(H_VISIBLE);
   localparam logic [15:0] HTotal  = 16'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
   localparam logic [15:0] HsStart = 16'(H_VISIBLE + H_FRONT);
   localparam logic [15:0] HsEnd   = 16'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [15:0] VVis    = 16'(V_VISIBLE);
   localparam logic [15:0] VTotal  = 16'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
   localparam logic [15:0] VsStart = 16'(V_VISIBLE + V_FRONT);
   localparam logic [15:0] VsEnd   = 16'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [15:0] Horizon = 16'(HORIZON);
   // Delay-line word {sky, vs_n, hs_n, active}; reset is the inactive pattern.
   localparam logic [3:0]  DlyRst  = 4'b0110;

   logic [15:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, angle_q, angle_d;
   logic [7:0]  rgb_q, rgb_d;
   logic        hsync_q, vsync_q;
   logic        h_end, v_end;
   logic [16:0] angle_sum;
   logic [3:0]  raw, dly;

   always_comb begin
      hcnt_d    = hcnt_q;
      vcnt_d    = vcnt_q;
      angle_d   = angle_q;
      h_end     = (hcnt_q == HTotal - 16'd1);
      v_end     = (vcnt_q == VTotal - 16'd1);
      angle_sum = {1'b0, angle_q} + {1'b0, angle_step_i};
      if (pix_ce_i) begin
         hcnt_d = h_end ? 16'd0 : hcnt_q + 16'd1;
         if (h_end) begin
            vcnt_d = v_end ? 16'd0 : vcnt_q + 16'd1;
         end
         // Out-of-range steps leave the angle untouched.
         if (h_end && v_end && (angle_step_i <= 16'd359)) begin
            angle_d = (angle_sum >= 17'd360) ? 16'(angle_sum - 17'd360) : 16'(angle_sum);
         end
      end
   end

   always_comb begin
      raw[0] = (hcnt_q < HVis) && (vcnt_q < VVis);
      raw[1] = !((hcnt_q >= HsStart) && (hcnt_q <= HsEnd));
      raw[2] = !((vcnt_q >= VsStart) && (vcnt_q <= VsEnd));
      raw[3] = (vcnt_q < Horizon);
   end

   if (PIPE_LAT == 0) begin : g_nodly
      assign dly = raw;
   end else begin : g_dly
      logic [3:0] pipe_q [PIPE_LAT];
      always_ff @(posedge clk) begin
         if (reset) begin
            for (int i = 0; i < int'(PIPE_LAT); i++) pipe_q[i] <= DlyRst;
         end else if (pix_ce_i) begin
            pipe_q[0] <= raw;
            for (int i = 1; i < int'(PIPE_LAT); i++) pipe_q[i] <= pipe_q[i-1];
         end
      end
      assign dly = pipe_q[PIPE_LAT-1];
   end

   always_comb begin
      rgb_d = 8'd0;
      if (dly[0]) begin
         rgb_d = (HorizonEn && dly[3]) ? SKY_COLOR : color_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt_q  <= 16'd0;
         vcnt_q  <= 16'd0;
         angle_q <= 16'd0;
         rgb_q   <= 8'd0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         angle_q <= angle_d;
         if (pix_ce_i) begin
            rgb_q   <= rgb_d;
            hsync_q <= dly[1];
            vsync_q <= dly[2];
         end
      end
   end

   assign x_o           = hcnt_q;
   assign y_o           = vcnt_q;
   assign angle_o       = angle_q;
   assign rgb_o         = rgb_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign frame_start_o = pix_ce_i && !reset && (hcnt_q == 16'd0) && (vcnt_q == 16'd0);

endmodule

// File: tb/tb_mode7_vga_scan.sv
// Randomized bench for mode7_vga_scan on a shrunken raster, checked every clock against a
// tick-count model of position, delayed sync/colour and frame-end angle updates.
module tb_mode7_vga_scan;

   localparam int HV = 16, HF = 2, HS = 3, HB = 3;
   localparam int VV = 10, VF = 1, VS = 2, VB = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int PL = 2;
   localparam int HZ = 4;
   localparam logic [7:0] SKY = 8'h13;
   localparam int N = 8192;
`ifdef MODE7_HORIZON_EN
   localparam bit HzEn = 1'b1;
`else
   localparam bit HzEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, pix_ce;
   logic [7:0]  color;
   logic [15:0] angle_step;
   logic [15:0] x_o, y_o, angle_o;
   logic [7:0]  rgb_o;
   logic        hsync_o, vsync_o, frame_start_o;

   always #5 clk = ~clk;

   mode7_vga_scan #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .PIPE_LAT(PL), .HORIZON(HZ), .SKY_COLOR(SKY)
   ) dut (
      .clk(clk), .reset(reset), .pix_ce_i(pix_ce), .color_i(color),
      .angle_step_i(angle_step), .x_o(x_o), .y_o(y_o), .angle_o(angle_o),
      .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .frame_start_o(frame_start_o)
   );

   // Model: m = pixel ticks since reset; everything else follows from m.
   int       m = 0, ang = 0;
   bit [7:0] col_hist [N];
   bit       started = 0, ticked = 0;
   int       n_chk = 0, n_err = 0;
   int       hs_lo = 0, vs_lo = 0, fs_cnt = 0;
   int       k;
   int       e_rgb, e_hs, e_vs, e_fs;

   function automatic int hp(input int p);
      return p % HT;
   endfunction

   function automatic int vp(input int p);
      return (p / HT) % VT;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (tick %0d, t=%0t)", nm, act, exp, m, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      ticked = 0;
      if (reset) begin
         m   = 0;
         ang = 0;
      end else if (pix_ce) begin
         col_hist[m % N] = color;
         if (hp(m) == HT-1 && vp(m) == VT-1 && angle_step <= 359)
            ang = (ang + int'(angle_step)) % 360;
         m++;
         ticked = 1;
      end
      started = 1;
   end

   initial forever begin
      @(negedge clk);
      if (started) begin
         k     = m - 1 - PL;
         e_rgb = 0;
         e_hs  = 1;
         e_vs  = 1;
         if (m > 0 && k >= 0) begin
            e_hs = (hp(k) >= HV+HF && hp(k) < HV+HF+HS) ? 0 : 1;
            e_vs = (vp(k) >= VV+VF && vp(k) < VV+VF+VS) ? 0 : 1;
            if (hp(k) < HV && vp(k) < VV)
               e_rgb = (HzEn && vp(k) < HZ) ? int'(SKY) : int'(col_hist[(m-1) % N]);
         end
         e_fs = (pix_ce && !reset && hp(m) == 0 && vp(m) == 0) ? 1 : 0;
         chk("x", x_o, hp(m));
         chk("y", y_o, vp(m));
         chk("angle", angle_o, ang);
         chk("rgb", rgb_o, e_rgb);
         chk("hsync", hsync_o, e_hs);
         chk("vsync", vsync_o, e_vs);
         chk("frame_start", frame_start_o, e_fs);
         if (ticked) begin
            if (!hsync_o) hs_lo++;
            if (!vsync_o) vs_lo++;
         end
         if (frame_start_o) fs_cnt++;
      end
   end

   // mode 0: pix_ce every clk, 1: every 4th clk, 2: random
   task automatic run(input int ticks, input int mode);
      int done = 0;
      int c = 0;
      while (done < ticks) begin
         @(posedge clk); #1;
         color = 8'($urandom);
         case (mode)
            0:       pix_ce = 1'b1;
            1:       pix_ce = (c % 4 == 3);
            default: pix_ce = ($urandom_range(0, 1) == 1);
         endcase
         c++;
         if (pix_ce) done++;
         if (c > ticks * 20 + 100) begin
            n_chk++;
            n_err++;
            $display("FAIL run_budget: got %0d ticks expected %0d", done, ticks);
            break;
         end
      end
      @(posedge clk); #1;
      pix_ce = 1'b0;
      @(negedge clk); #1;
   endtask

   initial begin
      reset      = 1'b1;
      pix_ce     = 1'b1;
      color      = 8'h00;
      angle_step = 16'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_x", x_o, 0);
      chk("rst_y", y_o, 0);
      chk("rst_angle", angle_o, 0);
      chk("rst_rgb", rgb_o, 0);
      chk("rst_hsync", hsync_o, 1);
      chk("rst_vsync", vsync_o, 1);
      @(posedge clk); #1;
      reset  = 1'b0;
      pix_ce = 1'b0;

      hs_lo = 0; vs_lo = 0; fs_cnt = 0;
      angle_step = 16'd175;
      run(HT*VT, 1);
      chk("hsync_low_ticks", hs_lo, HS * VT);
      chk("vsync_low_ticks", vs_lo, VS * HT);
      chk("frame_start_count", fs_cnt, 1);
      chk("angle_175", angle_o, 175);

      run(HT*VT, 2);
      chk("angle_350", angle_o, 350);
      angle_step = 16'd15;
      run(HT*VT, 0);
      chk("angle_wrap_5", angle_o, 5);
      angle_step = 16'd400;
      run(HT*VT, 2);
      chk("angle_step_400_hold", angle_o, 5);
      angle_step = 16'd0;
      run(HT*VT, 0);
      chk("angle_step_0_hold", angle_o, 5);

      run(100, 0);
      fs_cnt = 0;
      repeat (50) begin
         @(posedge clk); #1;
         pix_ce = 1'b0;
         color  = 8'($urandom);
      end
      @(negedge clk); #1;
      chk("stall_frame_start", fs_cnt, 0);

      repeat (3) begin
         angle_step = 16'($urandom_range(0, 500));
         run(HT*VT + int'($urandom_range(0, 50)), 2);
      end

      @(posedge clk); #1;
      reset  = 1'b1;
      pix_ce = 1'b1;
      @(posedge clk); #1;
      reset  = 1'b0;
      @(negedge clk);
      chk("midreset_x", x_o, 0);
      chk("midreset_y", y_o, 0);
      chk("midreset_angle", angle_o, 0);
      chk("midreset_frame_start", frame_start_o, 1);
      run(200, 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
